div_result_bcd: RTL and testbench



---
 rtl/div_result_bcd.sv | 165 ++++++++++++++++
 tb/tb_div_result_bcd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// Quotient/fraction to packed BCD converter with a shared double-dabble engine.
// Optional leading-zero blanking of the integer digits: DIV_BCD_LZ_BLANK_EN.
module div_result_bcd #(
  parameter int CONV_CYCLES = 16,
  parameter int FRAC_MAX    = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] q_in,
  input  logic [15:0] deci_in,
  input  logic        div_by_zero,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_int,
  output logic [15:0] bcd_frac,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] qbin_q, qbin_d;
  logic [15:0] fbin_q, fbin_d;
  logic [19:0] iacc_q, iacc_d;
  logic [15:0] facc_q, facc_d;
  logic        sat_q, sat_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [19:0] bint_q, bint_d;
  logic [15:0] bfrac_q, bfrac_d;

  logic [19:0] iadj;
  logic [15:0] fadj;
  logic [19:0] ires;
  logic        frac_sat;

  function automatic logic [19:0] adj20(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++)
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [15:0] adj16(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++)
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return r;
  endfunction

`ifdef DIV_BCD_LZ_BLANK_EN
  // Blank code 4'hF for leading zeros; the units digit always shows.
  function automatic logic [19:0] lz_blank(input logic [19:0] v);
    logic [19:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction
  assign ires = lz_blank(iacc_q);
`else
  assign ires = iacc_q;
`endif

  assign iadj     = adj20(iacc_q);
  assign fadj     = adj16(facc_q);
  assign frac_sat = deci_in > 16'(FRAC_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qbin_d  = qbin_q;
    fbin_d  = fbin_q;
    iacc_d  = iacc_q;
    facc_d  = facc_q;
    sat_d   = sat_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bint_d  = bint_q;
    bfrac_d = bfrac_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = 5'd0;
          qbin_d  = q_in;
          fbin_d  = frac_sat ? 16'(FRAC_MAX) : deci_in;
          sat_d   = frac_sat;
          dbz_d   = div_by_zero;
          iacc_d  = 20'd0;
          facc_d  = 16'd0;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        {iacc_d, qbin_d} = {iadj, qbin_q} << 1;
        {facc_d, fbin_d} = {fadj, fbin_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(CONV_CYCLES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = sat_q | dbz_q;
        bint_d  = dbz_q ? 20'd0 : ires;
        bfrac_d = dbz_q ? 16'd0 : facc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      qbin_q  <= 16'd0;
      fbin_q  <= 16'd0;
      iacc_q  <= 20'd0;
      facc_q  <= 16'd0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bint_q  <= 20'd0;
      bfrac_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qbin_q  <= qbin_d;
      fbin_q  <= fbin_d;
      iacc_q  <= iacc_d;
      facc_q  <= facc_d;
      sat_q   <= sat_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bint_q  <= bint_d;
      bfrac_q <= bfrac_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign bcd_int  = bint_q;
  assign bcd_frac = bfrac_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed self-checking bench for div_result_bcd.
// Expected digits are hand-computed constants.
module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] q_in;
  logic [15:0] deci_in;
  logic        div_by_zero;
  logic        busy;
  logic        done;
  logic [19:0] bcd_int;
  logic [15:0] bcd_frac;
  logic        err;

  int checks = 0;
  int errors = 0;

  div_result_bcd dut (
    .clk(clk), .rst(rst), .start(start),
    .q_in(q_in), .deci_in(deci_in),
    .div_by_zero(div_by_zero),
    .busy(busy), .done(done),
    .bcd_int(bcd_int), .bcd_frac(bcd_frac),
    .err(err)
  );

  always #5 clk = ~clk;

`ifdef DIV_BCD_LZ_BLANK_EN
  function automatic logic [19:0] ex_int(input logic [19:0] v);
    logic [19:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction
`else
  function automatic logic [19:0] ex_int(input logic [19:0] v);
    return v;
  endfunction
`endif

  // Call #1 after a rising edge; start is sampled on the next edge.
  task automatic run(input logic [15:0] q, input logic [15:0] d,
                     input logic z, output int lat,
                     output logic busy_ok, output logic done0);
    start = 1'b1; q_in = q; deci_in = d; div_by_zero = z;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy;
    done0 = done;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; q_in = '0; deci_in = '0; div_by_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, bcd_int, bcd_frac} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", {busy, done, err, bcd_int, bcd_frac});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat; logic bok, d0;
    run(16'd1234, 16'd5678, 1'b0, lat, bok, d0);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bok); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    checks++;
    if (bcd_int !== ex_int(20'h01234)) begin
      errors++; $display("FAIL basic_int got %h want %h", bcd_int, ex_int(20'h01234));
    end
    checks++;
    if (bcd_frac !== 16'h5678) begin errors++; $display("FAIL basic_frac got %h want 5678", bcd_frac); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
  endtask

  task automatic test_back_to_back;
    int lat; logic bok, d0;
    run(16'd65535, 16'd0, 1'b0, lat, bok, d0);
    checks++;
    if ({bcd_int, bcd_frac, err} !== {ex_int(20'h65535), 16'h0000, 1'b0}) begin
      errors++; $display("FAIL b2b_max got %h/%h/%b want 65535/0000/0", bcd_int, bcd_frac, err);
    end
    run(16'd0, 16'd9999, 1'b0, lat, bok, d0);
    checks++;
    if (d0 !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b want 0", d0); end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL b2b_latency got %0d want 17", lat); end
    checks++;
    if ({bcd_int, bcd_frac, err} !== {ex_int(20'h00000), 16'h9999, 1'b0}) begin
      errors++; $display("FAIL b2b_zero got %h/%h/%b want 00000/9999/0", bcd_int, bcd_frac, err);
    end
  endtask

  task automatic test_dbz;
    int ndone, first;
    ndone = 0; first = -1;
    start = 1'b1; q_in = 16'd65535; deci_in = 16'd1234; div_by_zero = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (first < 0) first = k; end
      if (k == 4) begin start = 1'b1; q_in = 16'd77; deci_in = 16'd77; div_by_zero = 1'b0; end
      if (k == 5) start = 1'b0;
    end
    checks++;
    if (ndone !== 1 || first !== 17) begin
      errors++; $display("FAIL dbz_done got %0d pulses at %0d want 1 at 17", ndone, first);
    end
    checks++;
    if ({bcd_int, bcd_frac, err} !== {20'h0, 16'h0, 1'b1}) begin
      errors++; $display("FAIL dbz_result got %h/%h/%b want 00000/0000/1", bcd_int, bcd_frac, err);
    end
  endtask

  task automatic test_saturate;
    int lat; logic bok, d0;
    run(16'd3, 16'd12000, 1'b0, lat, bok, d0);
    checks++;
    if ({bcd_int, bcd_frac, err} !== {ex_int(20'h00003), 16'h9999, 1'b1}) begin
      errors++; $display("FAIL sat_result got %h/%h/%b want 00003/9999/1", bcd_int, bcd_frac, err);
    end
    run(16'd5, 16'd1, 1'b0, lat, bok, d0);
    checks++;
    if ({bcd_int, bcd_frac, err} !== {ex_int(20'h00005), 16'h0001, 1'b0}) begin
      errors++; $display("FAIL sat_clear got %h/%h/%b want 00005/0001/0", bcd_int, bcd_frac, err);
    end
  endtask

  task automatic test_reset_mid;
    int ndone, lat; logic bok, d0;
    start = 1'b1; q_in = 16'd999; deci_in = 16'd0; div_by_zero = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, bcd_int, bcd_frac} !== 39'd0) begin
      errors++; $display("FAIL midrst_state got %h want 0", {busy, done, err, bcd_int, bcd_frac});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL midrst_nodone got %0d want 0", ndone); end
    run(16'd42, 16'd5, 1'b0, lat, bok, d0);
    checks++;
    if ({bcd_int, bcd_frac, err} !== {ex_int(20'h00042), 16'h0005, 1'b0}) begin
      errors++; $display("FAIL midrst_fresh got %h/%h/%b want 00042/0005/0", bcd_int, bcd_frac, err);
    end
  endtask

`ifdef DIV_BCD_LZ_BLANK_EN
  task automatic test_blank;
    int lat; logic bok, d0;
    run(16'd7, 16'd5, 1'b0, lat, bok, d0);
    checks++;
    if ({bcd_int, bcd_frac} !== {20'hFFFF7, 16'h0005}) begin
      errors++; $display("FAIL blank_7 got %h/%h want FFFF7/0005", bcd_int, bcd_frac);
    end
    run(16'd0, 16'd0, 1'b0, lat, bok, d0);
    checks++;
    if (bcd_int !== 20'hFFFF0) begin errors++; $display("FAIL blank_0 got %h want FFFF0", bcd_int); end
    run(16'd10203, 16'd0, 1'b0, lat, bok, d0);
    checks++;
    if (bcd_int !== 20'h10203) begin errors++; $display("FAIL blank_10203 got %h want 10203", bcd_int); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_dbz();
    test_saturate();
    test_reset_mid();
`ifdef DIV_BCD_LZ_BLANK_EN
    test_blank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
